demux_saida_reg: RTL

//  Registered 1-to-3 demultiplexer with valid/ready handshake; inverse of the datapath select muxes.

---
 rtl/demux_saida_reg.sv | 106 ++++++++++
 1 files changed

// File: rtl/demux_saida_reg.sv
// Registered 1-to-3 demultiplexer with valid/ready handshake and a one-entry output register per destination.
// Optional per-destination transfer counters are enabled by defining DEMUX_CONTADORES_EN.
module demux_saida_reg #(
  parameter int LARGURA = 8
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [LARGURA-1:0] Dado,
  input  logic [1:0]         Sinal,
  input  logic               Valido,
  output logic               Pronto,
  output logic [LARGURA-1:0] Saida0,
  output logic [LARGURA-1:0] Saida1,
  output logic [LARGURA-1:0] Saida2,
  output logic               Valido0,
  output logic               Valido1,
  output logic               Valido2,
  input  logic               Pronto0,
  input  logic               Pronto1,
  input  logic               Pronto2,
  output logic               Erro
`ifdef DEMUX_CONTADORES_EN
  ,
  output logic [7:0]         Contagem0,
  output logic [7:0]         Contagem1,
  output logic [7:0]         Contagem2
`endif
);

  logic [LARGURA-1:0] saida_reg [3];
  logic [2:0]         valido_reg;
  logic [2:0]         pronto_dest;
  logic [2:0]         escrita;
  logic [2:0]         dreno;
  logic [3:0]         sel_onehot;
  logic               aceite;
  logic               erro_reg;

  assign pronto_dest = {Pronto2, Pronto1, Pronto0};
  assign sel_onehot  = 4'b0001 << Sinal;

  // A full slot can still take new data in the same cycle its consumer drains it.
  always_comb begin
    Pronto = 1'b1;
    case (Sinal)
      2'd0:    Pronto = ~valido_reg[0] | pronto_dest[0];
      2'd1:    Pronto = ~valido_reg[1] | pronto_dest[1];
      2'd2:    Pronto = ~valido_reg[2] | pronto_dest[2];
      default: Pronto = 1'b1;
    endcase
  end

  assign aceite = Valido & Pronto;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dest
      assign escrita[gi] = aceite & sel_onehot[gi];
      assign dreno[gi]   = valido_reg[gi] & pronto_dest[gi];

      always_ff @(posedge Clock) begin
        if (!Reset_n) begin
          saida_reg[gi]  <= '0;
          valido_reg[gi] <= 1'b0;
        end else if (escrita[gi]) begin
          saida_reg[gi]  <= Dado;
          valido_reg[gi] <= 1'b1;
        end else if (dreno[gi]) begin
          valido_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Invalid destination: the beat is consumed and dropped, flagged for one cycle.
  always_ff @(posedge Clock) begin
    if (!Reset_n) erro_reg <= 1'b0;
    else          erro_reg <= aceite & sel_onehot[3];
  end

  assign Saida0  = saida_reg[0];
  assign Saida1  = saida_reg[1];
  assign Saida2  = saida_reg[2];
  assign Valido0 = valido_reg[0];
  assign Valido1 = valido_reg[1];
  assign Valido2 = valido_reg[2];
  assign Erro    = erro_reg;

`ifdef DEMUX_CONTADORES_EN
  logic [7:0] contagem_reg [3];

  generate
    for (gi = 0; gi < 3; gi++) begin : g_cont
      always_ff @(posedge Clock) begin
        if (!Reset_n)       contagem_reg[gi] <= 8'd0;
        else if (dreno[gi]) contagem_reg[gi] <= contagem_reg[gi] + 8'd1;
      end
    end
  endgenerate

  assign Contagem0 = contagem_reg[0];
  assign Contagem1 = contagem_reg[1];
  assign Contagem2 = contagem_reg[2];
`endif

endmodule
